// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request legality check for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 30;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legal = funct3 valid for the direction, naturally aligned, word index inside memory.
  function automatic logic lsu_is_legal(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input int unsigned mem_size);
    logic f3_ok;
    logic align_ok;
    logic range_ok;
    if (we) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_ok = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    case (f3)
      F3_H, F3_HU: align_ok = ~addr[0];
      F3_W:        align_ok = (addr[1:0] == 2'b00);
      default:     align_ok = 1'b1;
    endcase
    range_ok = 32'(addr[31:2]) < mem_size;
    return f3_ok && align_ok && range_ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus word-addressed data memory port.
interface lsu_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            mem_we;
  logic [XLEN-1:0] mem_a;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  // Environment side: the core plus the data memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: load lane extraction with extension, and store lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      F3_W:    merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: request classification, read-modify-write for sub-word
// stores and extended loads against a word-addressed memory with a single write enable.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 64
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  lsu_state_t       state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lo_q, lo_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  merge_q, merge_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [XLEN-1:0]  align_word;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  merged;

  // LOAD extracts from live memory data; WRITE merges into the word captured in RMW_READ.
  assign align_word = (state_q == ST_LOAD) ? bus.mem_rd : merge_q;

  lsu_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (lo_q),
    .word_i    (align_word),
    .wdata_i   (wdata_q),
    .load_o    (load_val),
    .merged_o  (merged)
  );

  assign bus.req_ready = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == ST_RESP) && !reset;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_we    = (state_q == ST_WRITE) && !reset;
  assign bus.mem_a     = ((state_q != ST_IDLE) && !reset) ? {2'b00, idx_q} : '0;
  assign bus.mem_wd    = bus.mem_we ? merged : '0;

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          f3_d    = bus.req_funct3;
          lo_d    = bus.req_addr[1:0];
          idx_d   = bus.req_addr[31:2];
          wdata_d = bus.req_wdata;
          merge_d = '0;
          rdata_d = '0;
          if (!lsu_is_legal(bus.req_we, bus.req_funct3, bus.req_addr, MEM_SIZE)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d = 1'b0;
            if (!bus.req_we)                 state_d = ST_LOAD;
            else if (bus.req_funct3 == F3_W) state_d = ST_WRITE;
            else                             state_d = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = load_val;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        merge_d = bus.mem_rd;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized requests against a
// byte-level reference model of the data memory.
module tb_lsu;

  localparam int unsigned MEM_WORDS = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu #(.MEM_SIZE(MEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int we_cnt = 0;
  int we_cyc = -1;
  logic [31:0] last_wd = '0;

  assign bus.mem_rd = (bus.mem_a < 32'(MEM_WORDS)) ? mem[bus.mem_a[5:0]] : '0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_a < 32'(MEM_WORDS)) mem[bus.mem_a[5:0]] <= bus.mem_wd;
      we_cnt  = we_cnt + 1;
      we_cyc  = cyc - start_cyc;
      last_wd = bus.mem_wd;
    end
    cyc <= cyc + 1;
  end

  // Reference model: plain byte arithmetic on a shadow copy of memory.
  function automatic bit ref_legal(bit we, int f3, logic [31:0] addr);
    bit ok;
    if (we) ok = (f3 <= 2);
    else    ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
    if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) ok = 0;
    if (f3 == 2 && (addr % 4 != 0)) ok = 0;
    if (addr / 4 >= 32'(MEM_WORDS)) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] ref_load(int f3, logic [31:0] addr);
    logic [31:0] w, b, h;
    int sh;
    w  = ref_mem[addr[7:2]];
    sh = int'(addr % 4) * 8;
    b  = (w >> sh) & 32'hFF;
    h  = (w >> sh) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? b - 32'd256 : b;
      1:       return (h >= 32768) ? h - 32'd65536 : h;
      4:       return b;
      5:       return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(int f3, logic [31:0] addr, logic [31:0] wdata);
    logic [31:0] w, mask;
    int sh;
    w  = ref_mem[addr[7:2]];
    sh = int'(addr % 4) * 8;
    if (f3 == 0)      mask = 32'hFF << sh;
    else if (f3 == 1) mask = 32'hFFFF << sh;
    else              mask = 32'hFFFF_FFFF;
    return (w & ~mask) | ((wdata << sh) & mask);
  endfunction

  task automatic preload();
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h0002_3BFF; ref_mem[0] = 32'h0002_3BFF;
    mem[1] = 32'h0002_39DF; ref_mem[1] = 32'h0002_39DF;
  endtask

  // Drives one request with rsp_ready held high and reports what the DUT did.
  task automatic run_req(input bit we, input int f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int wcnt,
                         output int wcyc, output logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = 3'(f3);
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    we_cnt    = 0;
    we_cyc    = -1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(posedge clk); #1;
    wcnt = we_cnt;
    wcyc = we_cyc;
    wd   = last_wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b expected 0", bus.req_ready); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_high: got %b expected 1", bus.req_ready); end
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_err, bus.mem_we} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b expected 000", {bus.rsp_valid, bus.rsp_err, bus.mem_we});
    end
    tests_run++;
    if ({bus.rsp_rdata, bus.mem_a, bus.mem_wd} !== 96'd0) begin
      fails++; $display("FAIL reset_data: rdata %h mem_a %h mem_wd %h expected all 0", bus.rsp_rdata, bus.mem_a, bus.mem_wd);
    end
  endtask

  task automatic test_loads();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    logic [31:0] addrs [3];
    int          f3s   [3];
    logic [31:0] exps  [3];
    addrs = '{32'h0, 32'h1, 32'h2};
    f3s   = '{0, 4, 5};
    exps  = '{32'hFFFF_FFFF, 32'h0000_003B, 32'h0000_0002};
    preload();
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat, wc, wy, wd);
      tests_run++;
      if (rd !== exps[i] || er !== 1'b0 || lat != 2) begin
        fails++; $display("FAIL load_%0d: rdata %h err %b lat %0d expected %h 0 2", i, rd, er, lat, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    preload();
    run_req(1'b1, 0, 32'h5, 32'h1234_56AA, rd, er, lat, wc, wy, wd);
    tests_run++;
    if (wc != 1 || wy != 2 || wd !== 32'h0002_AADF || lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL sb_write: we_cnt %0d at %0d wd %h lat %0d err %b rdata %h expected 1 2 0002aadf 3 0 0", wc, wy, wd, lat, er, rd);
    end
    run_req(1'b0, 2, 32'h4, 32'h0, rd, er, lat, wc, wy, wd);
    tests_run++;
    if (rd !== 32'h0002_AADF || wc != 0) begin fails++; $display("FAIL sb_readback: got %h expected 0002aadf", rd); end

    preload();
    run_req(1'b1, 1, 32'h6, 32'h0000_BEEF, rd, er, lat, wc, wy, wd);
    tests_run++;
    if (mem[1] !== 32'hBEEF_39DF || lat != 3 || wy != 2) begin
      fails++; $display("FAIL sh_write: word1 %h lat %0d we_at %0d expected beef39df 3 2", mem[1], lat, wy);
    end
    run_req(1'b1, 2, 32'h0, 32'hDEAD_BEEF, rd, er, lat, wc, wy, wd);
    tests_run++;
    if (lat != 2 || wc != 1 || wy != 1 || wd !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL sw_write: lat %0d we_cnt %0d at %0d wd %h expected 2 1 1 deadbeef", lat, wc, wy, wd);
    end
    run_req(1'b0, 2, 32'h0, 32'h0, rd, er, lat, wc, wy, wd);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_readback: got %h expected deadbeef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, wd; logic er; int lat, wc, wy;
    logic [31:0] addrs [3];
    int          f3s   [3];
    addrs = '{32'h2, 32'h3, 32'h100};
    f3s   = '{2, 1, 2};
    preload();
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat, wc, wy, wd);
      tests_run++;
      if (er !== 1'b1 || lat != 1 || wc != 0 || rd !== 32'h0) begin
        fails++; $display("FAIL error_%0d: err %b lat %0d we_cnt %0d rdata %h expected 1 1 0 0", i, er, lat, wc, rd);
      end
    end
    run_req(1'b1, 3, 32'h8, 32'hFFFF_FFFF, rd, er, lat, wc, wy, wd);
    tests_run++;
    if (er !== 1'b1 || lat != 1 || wc != 0 || mem[2] !== ref_mem[2]) begin
      fails++; $display("FAIL error_store_f3: err %b lat %0d we_cnt %0d expected 1 1 0", er, lat, wc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v0;
    int n;
    preload();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    we_cnt = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    v0 = bus.rsp_rdata;
    tests_run++;
    if (v0 !== 32'hFFFF_FFFF) begin fails++; $display("FAIL bp_value: got %h expected ffffffff", v0); end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== v0 || bus.req_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold_%0d: valid %b rdata %h ready %b expected 1 %h 0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, v0);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || we_cnt != 0 || mem[0] !== 32'h0002_3BFF) begin
      fails++; $display("FAIL bp_release: valid %b ready %b we_cnt %0d word0 %h expected 0 1 0 00023bff", bus.rsp_valid, bus.req_ready, we_cnt, mem[0]);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int seen;
    preload();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h5; bus.req_wdata = 32'h1234_56AA;
    we_cnt = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", bus.req_ready); end
    repeat (5) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
    tests_run++;
    if (we_cnt != 0 || seen != 0 || mem[1] !== 32'h0002_39DF) begin
      fails++; $display("FAIL rst_mid_abort: we_cnt %0d rsp_seen %0d word1 %h expected 0 0 000239df", we_cnt, seen, mem[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, addr, wdata, exp_rd;
    logic er;
    int lat, wc, wy, f3, exp_lat;
    bit we, legal;
    preload();
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    for (int t = 0; t < 80; t++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = int'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h10F));
      wdata = $urandom;
      legal = ref_legal(we, f3, addr);
      exp_rd = 32'h0;
      if (!legal)       exp_lat = 1;
      else if (!we)     begin exp_lat = 2; exp_rd = ref_load(f3, addr); end
      else if (f3 == 2) exp_lat = 2;
      else              exp_lat = 3;
      run_req(we, f3, addr, wdata, rd, er, lat, wc, wy, wd);
      tests_run++;
      if (rd !== exp_rd || er !== !legal || lat != exp_lat || wc != ((legal && we) ? 1 : 0)) begin
        fails++;
        $display("FAIL rand_%0d we=%0d f3=%0d addr=%h: rdata %h err %b lat %0d we_cnt %0d expected %h %b %0d %0d",
                 t, we, f3, addr, rd, er, lat, wc, exp_rd, !legal, exp_lat, (legal && we) ? 1 : 0);
      end
      if (legal && we) begin
        ref_mem[addr[7:2]] = ref_store(f3, addr, wdata);
        tests_run++;
        if (wd !== ref_mem[addr[7:2]] || wy != exp_lat - 1) begin
          fails++; $display("FAIL rand_store_%0d: mem_wd %h at %0d expected %h at %0d", t, wd, wy, ref_mem[addr[7:2]], exp_lat - 1);
        end
      end
    end
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      tests_run++;
      if (mem[i] !== ref_mem[i]) begin fails++; $display("FAIL rand_final_word_%0d: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    preload();
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_reset_mid_rmw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the core's memory stage and the word-addressed data memory. It accepts byte-addressed RV32I load/store requests over a valid/ready handshake and converts them to word-index accesses. It performs read-modify-write for byte/halfword stores, because the data memory has only a whole-word write enable, and it sign- or zero-extends load results. Misaligned, out-of-range and illegal requests are rejected without touching memory.

## Interface
- `MEM_SIZE`, 64: number of 32-bit words in the attached data memory. Must match the memory instance.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: high only in IDLE when `reset`=0. A transfer occurs when `req_valid` and `req_ready` are both high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits for SB/SH.
- `rsp_valid` out 1: response available. Held until `rsp_ready` is high.
- `rsp_ready` in 1: core accepts the response.
- `rsp_rdata` out 32: extended load data. Zero for stores and errors.
- `rsp_err` out 1: request was rejected. Qualified by `rsp_valid`.
- `mem_we` out 1: memory write enable.
- `mem_a` out 32: memory word index, equal to `req_addr[31:2]` zero-extended.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data, combinational from `mem_a`.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- On a handshake in IDLE, capture the op, address, `req_wdata` and word index, then classify the request:
  - Error if funct3 is illegal for the direction (load 011/110/111; store anything above 010).
  - Error if misaligned: halfword with `addr[0]`≠0, or word with `addr[1:0]`≠0.
  - Error if out of range: word index ≥ `MEM_SIZE`, checked over the full 30-bit index.
  - Error → RESP with `rsp_err`=1 and no memory access.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_READ.
- LOAD: drive `mem_a`, capture `mem_rd`, select the lane by `addr[1:0]` and extend. LB/LH sign-extend; LBU/LHU zero-extend. → RESP.
- RMW_READ: drive `mem_a` and capture `mem_rd` into the merge register. → WRITE.
- WRITE: `mem_we`=1 for exactly one cycle.
  - SW: `mem_wd` = `req_wdata`.
  - SB: merge register with byte lane `addr[1:0]` replaced by `wdata[7:0]`.
  - SH: merge register with halfword `addr[1]` replaced by `wdata[15:0]`.
  - → RESP.
- RESP: `rsp_valid`=1 with outputs stable. When `rsp_ready` is high → IDLE.
- `mem_we` is combinational (state==WRITE && !reset), so no write can issue in a reset cycle.
- `mem_a` holds the captured index outside IDLE and 0 in IDLE.

## Timing
- Latency from handshake (cycle 0) to first `rsp_valid`:
  - load: cycle 2
  - SW: cycle 2
  - SB/SH: cycle 3
  - error: cycle 1
- Throughput: one outstanding request. `req_ready` returns the cycle after the RESP handshake.
- Requests arriving while `req_ready`=0 are ignored. The core must hold them stable until accepted.
- `rsp_ready` already high on entering RESP: `rsp_valid` is high for exactly one cycle.
- Reset values: state IDLE; `req_ready` 0 during reset, 1 the first cycle after it; `rsp_valid`, `rsp_err`, `mem_we` 0; `rsp_rdata`, `mem_a`, `mem_wd` 0.
- Reset mid-operation aborts immediately. A pending WRITE is not performed and no response is produced.
- Memory write lands on the rising edge that ends WRITE. Loads issued later observe it.

## Structure
- Package `lsu_pkg` holds:
  - the state enum `lsu_state_t`;
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - a `lsu_is_legal` function covering funct3, alignment and range.
- One combinational sub-module, `lsu_align`. It performs lane extraction with extension, and store lane merge. Inputs: funct3, `addr[1:0]`, word, wdata. Outputs: load value, merged word.
- FSM and registers live in `lsu`.

## Test plan
All scenarios use memory preloaded with word0=0x00023BFF and word1=0x000239DF.
- LB at 0x0 → `rsp_rdata`=0xFFFFFFFF, `rsp_valid` at cycle 2. LBU at 0x1 → 0x0000003B. LHU at 0x2 → 0x00000002.
- SB at 0x5 with wdata 0x123456AA → `mem_we` asserted once, at cycle 2, `mem_wd`=0x0002AADF. A following LW at 0x4 → 0x0002AADF.
- SH at 0x6 with wdata 0xBEEF → word1=0xBEEF39DF. SW at 0x0 with 0xDEADBEEF → LW at 0x0 returns 0xDEADBEEF.
- LW at 0x2, LH at 0x3, and LW at 0x100 (`MEM_SIZE`=64) → `rsp_err`=1 at cycle 1, `mem_we` never high, `rsp_rdata`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_rdata` stable throughout, `req_ready`=0, a new `req_valid` is not accepted.
- Assert `reset` during the RMW_READ of an SB → `mem_we` stays 0, no response, `req_ready`=1 the cycle after reset deasserts.
